// File: rtl/led_pattern_pkg.sv
// Shared types and defaults for the LED pattern controller.
package led_pattern_pkg;

    localparam int NUM_LEDS_DEF = 4;
    localparam int PWM_BITS_DEF = 8;
    localparam int PRESCALE_DEF = 1000;
    localparam int PERIOD_W_DEF = 16;

    typedef enum logic [1:0] {
        LED_OFF    = 2'd0,
        LED_STATIC = 2'd1,
        LED_BLINK  = 2'd2,
        LED_SHIFT  = 2'd3
    } led_mode_e;

    // Configuration record at the default widths.
    typedef struct packed {
        led_mode_e                 mode;
        logic [NUM_LEDS_DEF-1:0]   pattern;
        logic [PWM_BITS_DEF-1:0]   duty;
        logic [PERIOD_W_DEF-1:0]   period;
    } led_cfg_t;

endpackage

// File: rtl/led_pattern_ctrl_if.sv
// Configuration valid/ready handoff between the register file (master) and the LED controller (slave).
interface led_pattern_ctrl_if #(
    parameter int NUM_LEDS = 4,
    parameter int PWM_BITS = 8,
    parameter int PERIOD_W = 16
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [1:0]          cfg_mode;
    logic [NUM_LEDS-1:0] cfg_pattern;
    logic [PWM_BITS-1:0] cfg_duty;
    logic [PERIOD_W-1:0] cfg_period;

    modport master (
        output cfg_valid, cfg_mode, cfg_pattern, cfg_duty, cfg_period,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_mode, cfg_pattern, cfg_duty, cfg_period,
        output cfg_ready
    );
endinterface

// File: rtl/led_pattern_ctrl_pwm_gen.sv
// Free-running PWM frame counter with a registered effective duty.
// Optional LED_PATTERN_GAMMA_EN squares the duty when it is loaded.
module led_pwm_gen #(
    parameter int PWM_BITS = 8
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                load_i,
    input  logic [PWM_BITS-1:0] duty_i,
    output logic                frame_start_o,
    output logic                pwm_on_o
);
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] duty_q;

    function automatic logic [PWM_BITS-1:0] eff_duty(input logic [PWM_BITS-1:0] d);
`ifdef LED_PATTERN_GAMMA_EN
        logic [2*PWM_BITS-1:0] sq;
        sq = {{PWM_BITS{1'b0}}, d} * {{PWM_BITS{1'b0}}, d};
        if (d == CNT_MAX) begin
            eff_duty = CNT_MAX;
        end else begin
            eff_duty = sq[2*PWM_BITS-1:PWM_BITS];
        end
`else
        eff_duty = d;
`endif
    endfunction

    // Frame counter and duty register; duty only changes on an apply.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            pwm_cnt_q <= '0;
            duty_q    <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            if (load_i) begin
                duty_q <= eff_duty(duty_i);
            end
        end
    end

    // High on the last count, so the edge that acts on it lands on pwm_cnt = 0.
    assign frame_start_o = (pwm_cnt_q == CNT_MAX);
    assign pwm_on_o      = (pwm_cnt_q < duty_q) || (duty_q == CNT_MAX);

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: accepts a configuration, applies it at a PWM frame boundary,
// and drives static/blink/shift patterns. Build option: LED_PATTERN_GAMMA_EN.
module led_pattern_ctrl
    import led_pattern_pkg::*;
#(
    parameter int NUM_LEDS = NUM_LEDS_DEF,
    parameter int PWM_BITS = PWM_BITS_DEF,
    parameter int PRESCALE = PRESCALE_DEF,
    parameter int PERIOD_W = PERIOD_W_DEF
) (
    input  logic                ACLK,
    input  logic                ARESET,
    led_pattern_ctrl_if.slave   cfg,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                cfg_pending
);
    localparam int PS_W = $clog2(PRESCALE);

    typedef struct packed {
        led_mode_e           mode;
        logic [NUM_LEDS-1:0] pattern;
        logic [PWM_BITS-1:0] duty;
        logic [PERIOD_W-1:0] period;
    } cfg_t;

    cfg_t                 shadow_q;
    logic                ready_q;
    logic                pending_q;
    led_mode_e           mode_q;
    logic [NUM_LEDS-1:0] pattern_q;
    logic [PERIOD_W-1:0] period_q;
    logic                phase_q;
    logic [PS_W-1:0]     presc_q;
    logic [PERIOD_W-1:0] step_q;
    logic [NUM_LEDS-1:0] led_q;

    logic                frame_start_s;
    logic                pwm_on_s;
    logic                apply_s;
    logic                tick_s;
    logic                step_s;
    logic [PERIOD_W-1:0] period_eff_s;
    logic [NUM_LEDS-1:0] lit_s;
    logic [NUM_LEDS-1:0] led_d;

    led_pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .load_i        (apply_s),
        .duty_i        (shadow_q.duty),
        .frame_start_o (frame_start_s),
        .pwm_on_o      (pwm_on_s)
    );

    // Apply/tick/step decode and the next LED drive for the active mode.
    always_comb begin
        apply_s      = pending_q && frame_start_s;
        tick_s       = (presc_q == PS_W'(PRESCALE - 1));
        period_eff_s = (period_q == '0) ? PERIOD_W'(1) : period_q;
        step_s       = tick_s && (step_q == period_eff_s - PERIOD_W'(1));
        lit_s        = pattern_q & {NUM_LEDS{pwm_on_s}};
        case (mode_q)
            LED_OFF:    led_d = '0;
            LED_STATIC: led_d = lit_s;
            LED_BLINK:  led_d = phase_q ? lit_s : '0;
            LED_SHIFT:  led_d = lit_s;
            default:    led_d = '0;
        endcase
    end

    // Handshake, shadow/active configuration, pattern timing and output register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            shadow_q  <= '0;
            ready_q   <= 1'b1;
            pending_q <= 1'b0;
            mode_q    <= LED_OFF;
            pattern_q <= '0;
            period_q  <= PERIOD_W'(1);
            phase_q   <= 1'b0;
            presc_q   <= '0;
            step_q    <= '0;
            led_q     <= '0;
        end else begin
            led_q <= led_d;

            if (cfg.cfg_valid && ready_q) begin
                shadow_q  <= '{mode:    led_mode_e'(cfg.cfg_mode),
                               pattern: cfg.cfg_pattern,
                               duty:    cfg.cfg_duty,
                               period:  cfg.cfg_period};
                ready_q   <= 1'b0;
                pending_q <= 1'b1;
            end else if (apply_s) begin
                ready_q   <= 1'b1;
                pending_q <= 1'b0;
            end

            // An apply restarts the pattern timing and swallows any coincident step.
            if (apply_s) begin
                mode_q    <= shadow_q.mode;
                pattern_q <= shadow_q.pattern;
                period_q  <= shadow_q.period;
                phase_q   <= 1'b1;
                presc_q   <= '0;
                step_q    <= '0;
            end else begin
                presc_q <= tick_s ? '0 : presc_q + PS_W'(1);
                if (tick_s) begin
                    step_q <= step_s ? '0 : step_q + PERIOD_W'(1);
                end
                if (step_s) begin
                    case (mode_q)
                        LED_BLINK: phase_q   <= ~phase_q;
                        LED_SHIFT: pattern_q <= {pattern_q[NUM_LEDS-2:0], pattern_q[NUM_LEDS-1]};
                        default:   ;
                    endcase
                end
            end
        end
    end

    assign cfg.cfg_ready = ready_q;
    assign cfg_pending   = pending_q;
    assign led_out       = led_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed self-checking bench for led_pattern_ctrl (PRESCALE=4); honours LED_PATTERN_GAMMA_EN.
module tb_led_pattern_ctrl;
    import led_pattern_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] led_out;
    logic       cfg_pending;
    int         vectors;
    int         miscompares;

    led_pattern_ctrl_if #(.NUM_LEDS(4), .PWM_BITS(8), .PERIOD_W(16)) cfg_if ();

    led_pattern_ctrl #(
        .NUM_LEDS (4),
        .PWM_BITS (8),
        .PRESCALE (4),
        .PERIOD_W (16)
    ) dut (
        .ACLK        (clk),
        .ARESET      (rst),
        .cfg         (cfg_if),
        .led_out     (led_out),
        .cfg_pending (cfg_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one configuration for a single clock; call and return at a negedge.
    task automatic offer(input led_cfg_t c);
        cfg_if.cfg_valid   = 1'b1;
        cfg_if.cfg_mode    = c.mode;
        cfg_if.cfg_pattern = c.pattern;
        cfg_if.cfg_duty    = c.duty;
        cfg_if.cfg_period  = c.period;
        @(negedge clk);
        cfg_if.cfg_valid   = 1'b0;
    endtask

    task automatic wait_apply(output int waited);
        waited = 0;
        while (cfg_if.cfg_ready !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic count_on(input logic [3:0] pat, input int n, output int on, output int off);
        on = 0;
        off = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (led_out === pat) on++;
            else if (led_out === 4'b0000) off++;
        end
    endtask

    task automatic test_reset();
        cfg_if.cfg_valid   = 1'b1;
        cfg_if.cfg_mode    = 2'd1;
        cfg_if.cfg_pattern = 4'hF;
        cfg_if.cfg_duty    = 8'hFF;
        cfg_if.cfg_period  = 16'd1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        vectors++;
        if (cfg_if.cfg_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", cfg_if.cfg_ready); end
        vectors++;
        if (cfg_pending !== 1'b0) begin miscompares++; $display("FAIL reset_pending: got %b want 0", cfg_pending); end
        vectors++;
        if (led_out !== 4'b0000) begin miscompares++; $display("FAIL reset_led: got %b want 0000", led_out); end
        @(negedge clk);
        vectors++;
        if (cfg_pending !== 1'b0) begin miscompares++; $display("FAIL valid_in_reset: pending %b want 0", cfg_pending); end
    endtask

    task automatic test_static_full();
        led_cfg_t c;
        int waited, on, off;
        c = '{mode: LED_STATIC, pattern: 4'b1010, duty: 8'hFF, period: 16'd1};
        repeat (9) @(negedge clk);
        offer(c);
        vectors++;
        if (cfg_if.cfg_ready !== 1'b0) begin miscompares++; $display("FAIL accept_ready: got %b want 0", cfg_if.cfg_ready); end
        vectors++;
        if (cfg_pending !== 1'b1) begin miscompares++; $display("FAIL accept_pending: got %b want 1", cfg_pending); end
        vectors++;
        if (led_out !== 4'b0000) begin miscompares++; $display("FAIL pre_apply_led: got %b want 0000", led_out); end
        wait_apply(waited);
        vectors++;
        if (waited !== 245) begin miscompares++; $display("FAIL apply_latency: got %0d want 245", waited); end
        vectors++;
        if (cfg_pending !== 1'b0) begin miscompares++; $display("FAIL apply_pending: got %b want 0", cfg_pending); end
        vectors++;
        if (led_out !== 4'b0000) begin miscompares++; $display("FAIL apply_lag: got %b want 0000", led_out); end
        count_on(4'b1010, 256, on, off);
        vectors++;
        if (on !== 256) begin miscompares++; $display("FAIL static_full_on: got %0d want 256", on); end
    endtask

    task automatic test_pwm_duty(input logic [7:0] duty, input int exp_on);
        led_cfg_t c;
        int waited, on, off;
        c = '{mode: LED_STATIC, pattern: 4'b1111, duty: duty, period: 16'd1};
        offer(c);
        wait_apply(waited);
        vectors++;
        if (waited >= 400) begin miscompares++; $display("FAIL pwm_apply_timeout: duty %h waited %0d", duty, waited); end
        count_on(4'hF, 256, on, off);
        vectors++;
        if (on !== exp_on) begin miscompares++; $display("FAIL pwm_on_count: duty %h got %0d want %0d", duty, on, exp_on); end
        vectors++;
        if (off !== 256 - exp_on) begin miscompares++; $display("FAIL pwm_off_count: duty %h got %0d want %0d", duty, off, 256 - exp_on); end
    endtask

    task automatic test_blink();
        led_cfg_t c;
        int waited;
        logic [3:0] exp;
        c = '{mode: LED_BLINK, pattern: 4'b0011, duty: 8'hFF, period: 16'd2};
        offer(c);
        wait_apply(waited);
        vectors++;
        if (waited >= 400) begin miscompares++; $display("FAIL blink_apply_timeout: waited %0d", waited); end
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            exp = (((k - 1) / 8) % 2 == 0) ? 4'b0011 : 4'b0000;
            vectors++;
            if (led_out !== exp) begin miscompares++; $display("FAIL blink k=%0d: got %b want %b", k, led_out, exp); end
        end
    endtask

    task automatic test_shift(input logic [15:0] period);
        led_cfg_t c;
        int waited;
        logic [3:0] exp;
        c = '{mode: LED_SHIFT, pattern: 4'b0001, duty: 8'hFF, period: period};
        offer(c);
        wait_apply(waited);
        vectors++;
        if (waited >= 400) begin miscompares++; $display("FAIL shift_apply_timeout: period %0d", period); end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp = 4'b0001;
            exp = exp << (((k - 1) / 4) % 4);
            vectors++;
            if (led_out !== exp) begin miscompares++; $display("FAIL shift p=%0d k=%0d: got %b want %b", period, k, led_out, exp); end
        end
    endtask

    task automatic test_back_to_back();
        led_cfg_t a, b;
        int waited;
        a = '{mode: LED_STATIC, pattern: 4'b0101, duty: 8'hFF, period: 16'd1};
        b = '{mode: LED_SHIFT,  pattern: 4'b1000, duty: 8'hFF, period: 16'd1};
        offer(a);
        offer(b);
        vectors++;
        if (cfg_if.cfg_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready: got %b want 0", cfg_if.cfg_ready); end
        vectors++;
        if (cfg_pending !== 1'b1) begin miscompares++; $display("FAIL b2b_pending: got %b want 1", cfg_pending); end
        wait_apply(waited);
        vectors++;
        if (waited >= 400) begin miscompares++; $display("FAIL b2b_apply_timeout: waited %0d", waited); end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            vectors++;
            if (led_out !== 4'b0101) begin miscompares++; $display("FAIL b2b_first_wins k=%0d: got %b want 0101", k, led_out); end
        end
    endtask

    task automatic test_reset_mid_pending();
        led_cfg_t c;
        int lit;
        c = '{mode: LED_STATIC, pattern: 4'b1111, duty: 8'hFF, period: 16'd1};
        offer(c);
        vectors++;
        if (cfg_pending !== 1'b1) begin miscompares++; $display("FAIL midrst_pending_before: got %b want 1", cfg_pending); end
        vectors++;
        if (led_out !== 4'b0101) begin miscompares++; $display("FAIL midrst_led_before: got %b want 0101", led_out); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (led_out !== 4'b0000) begin miscompares++; $display("FAIL midrst_led: got %b want 0000", led_out); end
        vectors++;
        if (cfg_pending !== 1'b0) begin miscompares++; $display("FAIL midrst_pending: got %b want 0", cfg_pending); end
        vectors++;
        if (cfg_if.cfg_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready: got %b want 1", cfg_if.cfg_ready); end
        lit = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (led_out !== 4'b0000) lit++;
        end
        vectors++;
        if (lit !== 0) begin miscompares++; $display("FAIL midrst_shadow_cleared: lit cycles %0d want 0", lit); end
    endtask

    initial begin
        vectors            = 0;
        miscompares        = 0;
        rst                = 1'b0;
        cfg_if.cfg_valid   = 1'b0;
        cfg_if.cfg_mode    = 2'd0;
        cfg_if.cfg_pattern = 4'h0;
        cfg_if.cfg_duty    = 8'h00;
        cfg_if.cfg_period  = 16'd0;
        test_reset();
        test_static_full();
`ifdef LED_PATTERN_GAMMA_EN
        test_pwm_duty(8'h40, 16);
        test_pwm_duty(8'h80, 64);
`else
        test_pwm_duty(8'h40, 64);
        test_pwm_duty(8'h80, 128);
`endif
        test_pwm_duty(8'h00, 0);
        test_blink();
        test_shift(16'd1);
        test_shift(16'd0);
        test_back_to_back();
        test_reset_mid_pending();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
- Downstream consumer of the Led_ip AXI4-Lite register file.
- Takes the decoded LED configuration (mode, pattern, duty, period) through a valid/ready handoff.
- Drives NUM_LEDS physical LED pins with static, blinking or rotating patterns, brightness-controlled by PWM.
- New configurations are applied only at PWM frame boundaries, so the LEDs never glitch.

Parameters:
- NUM_LEDS, 4, number of LED outputs.
- PWM_BITS, 8, PWM counter and duty width; one frame = 2^PWM_BITS clocks.
- PRESCALE, 1000, ACLK cycles per pattern tick (>=2).
- PERIOD_W, 16, width of cfg_period.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous reset, active-high.
- cfg_valid  in  1  new configuration offered.
- cfg_ready  out  1  block can accept a configuration.
- cfg_mode  in  2  0=OFF, 1=STATIC, 2=BLINK, 3=SHIFT.
- cfg_pattern  in  NUM_LEDS  base LED pattern.
- cfg_duty  in  PWM_BITS  brightness; all-ones = fully on.
- cfg_period  in  PERIOD_W  ticks per blink/shift step; 0 is treated as 1.
- led_out  out  NUM_LEDS  registered LED drive.
- cfg_pending  out  1  configuration accepted but not yet applied.

Behaviour:
- Reset values: cfg_ready=1, cfg_pending=0, led_out=0, active mode=OFF, pattern=0, duty=0, period=1, all counters=0.
- Handshake:
  - Accept on cfg_valid&&cfg_ready; fields latch into shadow registers.
  - cfg_ready drops and cfg_pending rises the cycle after accept.
  - Inputs are ignored while cfg_ready=0.
- Apply:
  - Apply happens on the cycle where pwm_cnt wraps to 0 and cfg_pending=1.
  - On apply: active <= shadow; cur_pattern <= shadow pattern; step_cnt and prescaler cleared; blink phase <= on.
  - Next cycle: cfg_pending=0, cfg_ready=1.
  - Worst-case accept-to-apply is 2^PWM_BITS clocks.
- PWM:
  - pwm_cnt increments every clock and wraps at 2^PWM_BITS-1.
  - pwm_on = (pwm_cnt < duty) || (duty == all-ones).
  - duty=0 gives always off.
- Tick:
  - prescaler counts 0..PRESCALE-1; tick pulses for 1 cycle at wrap.
  - step_cnt counts ticks; a step fires when step_cnt reaches max(period,1)-1, after which step_cnt returns to 0.
- State machine, per active mode:
  - OFF: led_out=0.
  - STATIC: led_out = cur_pattern & {NUM_LEDS{pwm_on}}.
  - BLINK: the step toggles phase; led_out = phase ? STATIC value : 0.
  - SHIFT: the step rotates cur_pattern left by 1 (MSB -> bit0); output as in STATIC.
- Latency: led_out is registered and lags pwm_on/cur_pattern by 1 clock.
- Simultaneous events:
  - A step and an apply in the same cycle: apply wins and the step is discarded.
  - cfg_valid during reset: ignored.
- Reset mid-operation clears the shadow and pending config immediately; the next cycle has cfg_ready=1.
- Width rules: all counters are unsigned and wrap naturally; no arithmetic overflow is visible at the outputs.

Optional Feature:
- Macro LED_PATTERN_GAMMA_EN.
- Defined: the effective duty is (duty*duty) >> PWM_BITS, computed at apply time and stored registered. all-ones stays fully on and 0 stays off.
- Undefined: duty is used linearly.
- Handshake and timing are identical in both builds.

Decomposition:
- Package led_pattern_pkg:
  - mode enum led_mode_e (LED_OFF, LED_STATIC, LED_BLINK, LED_SHIFT).
  - cfg struct led_cfg_t {mode, pattern, duty, period}.
  - default constants: PWM_BITS_DEF, PRESCALE_DEF.
- One sub-module, led_pwm_gen: pwm_cnt, frame_start pulse, and pwm_on from duty (plus the gamma path when enabled).
- Top handles the handshake, shadow/active registers, prescaler, step counter, mode FSM and output register.

Test Plan:
- After reset, STATIC pattern=4'b1010 duty=8'hFF offered at cycle 10 -> cfg_ready=0 next cycle; at the first pwm_cnt wrap led_out=4'b1010 held constant; cfg_ready returns 1.
- STATIC pattern=4'b1111 duty=8'h40 (PRESCALE=4 for sim) -> each 256-clock frame has exactly 64 clocks with led_out=4'hF and 192 with led_out=0.
- BLINK pattern=4'b0011 duty=FF period=2, PRESCALE=4 -> led_out alternates 4'b0011 / 0 every 8 clocks after apply.
- SHIFT pattern=4'b0001 period=1, PRESCALE=4 -> led_out sequence 0001, 0010, 0100, 1000, 0001, one step per 4 clocks; period=0 behaves identically.
- Second cfg_valid while cfg_pending=1 -> not accepted, first config applied; ARESET asserted mid-pending -> led_out=0, cfg_pending=0, cfg_ready=1 next cycle.
- With LED_PATTERN_GAMMA_EN, duty=8'h80 -> 64 on-clocks per frame; without it -> 128 on-clocks.
